// File: rtl/rv523_panel_pkg.sv
// Shared state encoding, timing defaults and counter sizing for the
// front-panel run/halt/single-step controller.
package rv523_panel_pkg;

    typedef enum logic [2:0] {
        ST_HALTED     = 3'd0,
        ST_PULSE_RUN  = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_PULSE_HALT = 3'd3,
        ST_STEP       = 3'd4
    } panel_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int PULSE_CYCLES_DEF    = 2;

    // Bits needed to hold the values 0..n-1, never fewer than one.
    function automatic int cntWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// One panel button: 2-flop synchronizer, stability counter and a
// single-cycle press event on each accepted release-to-pressed transition.
module panel_debounce
    import rv523_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int DW = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          syncMeta_q;
    logic          syncOut_q;
    logic          level_q;
    logic          press_q;
    logic [DW-1:0] stableCnt_q;

    // The level only moves after the synchronized input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncMeta_q  <= 1'b1;
            syncOut_q   <= 1'b1;
            level_q     <= 1'b1;
            press_q     <= 1'b0;
            stableCnt_q <= '0;
        end else begin
            syncMeta_q <= btn_n_i;
            syncOut_q  <= syncMeta_q;
            press_q    <= 1'b0;
            if (syncOut_q == level_q) begin
                stableCnt_q <= '0;
            end else if (stableCnt_q == CNT_LAST) begin
                level_q     <= syncOut_q;
                press_q     <= ~syncOut_q;
                stableCnt_q <= '0;
            end else begin
                stableCnt_q <= stableCnt_q + DW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/panel_halt_ctrl.sv
// Run/halt/single-step controller driving the halt SR latch with timed
// active-low pulses and checking that the latch follows each command.
module panel_halt_ctrl
    import rv523_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run_n,
    input  logic       btn_halt_n,
    input  logic       btn_step_n,
    input  logic       latch_q,
    output logic       latch_nS,
    output logic       latch_nR,
    output logic       cpu_clk_en,
    output logic [2:0] state_o,
    output logic       fault
);

    localparam int PW = cntWidth(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_CHECK = PW'(PULSE_CYCLES);

    logic runPress;
    logic haltPress;
    logic stepPress;

    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbRun (
        .clk(clk), .rst_n(rst_n), .btn_n_i(btn_run_n), .press_o(runPress)
    );
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbHalt (
        .clk(clk), .rst_n(rst_n), .btn_n_i(btn_halt_n), .press_o(haltPress)
    );
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbStep (
        .clk(clk), .rst_n(rst_n), .btn_n_i(btn_step_n), .press_o(stepPress)
    );

    panel_state_e  state_q;
    logic [PW-1:0] pulseCnt_q;
    logic          nS_q;
    logic          nR_q;
    logic          clkEn_q;
    logic          fault_q;

    // Pulse states count 0..PULSE_CYCLES-1 with the pin low, then spend one
    // cycle at PULSE_CHECK with the pin released before judging latch_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_HALTED;
            pulseCnt_q <= '0;
            nS_q       <= 1'b0;
            nR_q       <= 1'b1;
            clkEn_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            nS_q    <= 1'b1;
            nR_q    <= 1'b1;
            clkEn_q <= 1'b0;
            case (state_q)
                ST_HALTED: begin
                    if (runPress && !haltPress) begin
                        state_q    <= ST_PULSE_RUN;
                        nR_q       <= 1'b0;
                        pulseCnt_q <= '0;
                    end else if (stepPress && !haltPress) begin
                        state_q <= ST_STEP;
                        clkEn_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_HALTED;
                end
                ST_PULSE_RUN: begin
                    if (pulseCnt_q == PULSE_CHECK) begin
                        if (latch_q) begin
                            fault_q    <= 1'b1;
                            state_q    <= ST_PULSE_HALT;
                            nS_q       <= 1'b0;
                            pulseCnt_q <= '0;
                        end else begin
                            state_q <= ST_RUNNING;
                            clkEn_q <= 1'b1;
                        end
                    end else begin
                        pulseCnt_q <= pulseCnt_q + PW'(1);
                        nR_q       <= (pulseCnt_q == PULSE_LAST);
                    end
                end
                ST_RUNNING: begin
                    if (haltPress || latch_q) begin
                        if (latch_q) begin
                            fault_q <= 1'b1;
                        end
                        state_q    <= ST_PULSE_HALT;
                        nS_q       <= 1'b0;
                        pulseCnt_q <= '0;
                    end else begin
                        clkEn_q <= 1'b1;
                    end
                end
                ST_PULSE_HALT: begin
                    if (pulseCnt_q == PULSE_CHECK) begin
                        if (!latch_q) begin
                            fault_q <= 1'b1;
                        end
                        state_q <= ST_HALTED;
                    end else begin
                        pulseCnt_q <= pulseCnt_q + PW'(1);
                        nS_q       <= (pulseCnt_q == PULSE_LAST);
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign latch_nS   = nS_q;
    assign latch_nR   = nR_q;
    assign cpu_clk_en = clkEn_q;
    assign state_o    = state_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_panel_halt_ctrl.sv
// Bench for panel_halt_ctrl with a behavioural SR latch; state transitions are
// scoreboarded against expected cycle numbers, pin timing is checked inline.
module tb_panel_halt_ctrl;

    localparam logic [2:0] HALTED     = 3'd0;
    localparam logic [2:0] PULSE_RUN  = 3'd1;
    localparam logic [2:0] RUNNING    = 3'd2;
    localparam logic [2:0] PULSE_HALT = 3'd3;
    localparam logic [2:0] STEP       = 3'd4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       btn_run_n  = 1'b1;
    logic       btn_halt_n = 1'b1;
    logic       btn_step_n = 1'b1;
    logic       latch_q;
    logic       latch_nS;
    logic       latch_nR;
    logic       cpu_clk_en;
    logic [2:0] state_o;
    logic       fault;

    logic       modelQ    = 1'b1;
    logic       stuckHigh = 1'b0;
    logic [2:0] prevState = 3'd0;
    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;

    typedef struct {
        logic [2:0] st;
        int         at;
    } sbEntry_t;
    sbEntry_t sbQueue[$];

    panel_halt_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_run_n(btn_run_n), .btn_halt_n(btn_halt_n),
        .btn_step_n(btn_step_n), .latch_q(latch_q), .latch_nS(latch_nS),
        .latch_nR(latch_nR), .cpu_clk_en(cpu_clk_en), .state_o(state_o), .fault(fault)
    );

    always #5 clk = ~clk;

    // Set dominates, then reset, otherwise the latch holds.
    always @(latch_nS or latch_nR) begin
        if (latch_nS === 1'b0) modelQ = 1'b1;
        else if (latch_nR === 1'b0) modelQ = 1'b0;
    end
    assign latch_q = stuckHigh ? 1'b1 : modelQ;

    task automatic expectState(input logic [2:0] st, input int at);
        sbEntry_t e;
        e.st = st;
        e.at = at;
        sbQueue.push_back(e);
    endtask

    // Advances on falling edges; pin invariants every cycle, and each state
    // change is matched against the next scoreboard entry.
    task automatic run_cycles(input int n);
        sbEntry_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if ((latch_nS | latch_nR) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL latch_pins cyc %0d: nS=%b nR=%b, need at least one high", cyc, latch_nS, latch_nR);
            end
            checks++;
            if (cpu_clk_en !== 1'b0 && state_o !== RUNNING && state_o !== STEP) begin
                errors++;
                $display("[TB] FAIL clk_en_state cyc %0d: cpu_clk_en=%b in state %0d, want 0", cyc, cpu_clk_en, state_o);
            end
            if (state_o !== prevState) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected cyc %0d: state %0d -> %0d, want no change", cyc, prevState, state_o);
                end else begin
                    e = sbQueue.pop_front();
                    if (state_o !== e.st || cyc != e.at) begin
                        errors++;
                        $display("[TB] FAIL sb_transition: got state %0d at cyc %0d, want state %0d at cyc %0d", state_o, cyc, e.st, e.at);
                    end
                end
                prevState = state_o;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run_cycles(3);
        checks++;
        if (latch_nS !== 1'b0) begin errors++; $display("[TB] FAIL reset_nS: got %b want 0", latch_nS); end
        checks++;
        if (latch_nR !== 1'b1) begin errors++; $display("[TB] FAIL reset_nR: got %b want 1", latch_nR); end
        checks++;
        if (cpu_clk_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_en: got %b want 0", cpu_clk_en); end
        checks++;
        if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
        checks++;
        if (state_o !== HALTED) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", state_o, HALTED); end
        rst_n = 1'b1;
        run_cycles(1);
        checks++;
        if (latch_nS !== 1'b1) begin errors++; $display("[TB] FAIL release_nS: got %b want 1", latch_nS); end
    endtask

    task automatic test_run_press();
        int   t0;
        logic wantNR;
        logic wantEn;
        t0 = cyc;
        btn_run_n = 1'b0;
        expectState(PULSE_RUN, t0 + 7);
        expectState(RUNNING, t0 + 10);
        for (int k = 1; k <= 14; k++) begin
            run_cycles(1);
            wantNR = (k == 7 || k == 8) ? 1'b0 : 1'b1;
            wantEn = (k >= 10);
            checks++;
            if (latch_nR !== wantNR) begin errors++; $display("[TB] FAIL run_nR cycle %0d: got %b want %b", k, latch_nR, wantNR); end
            checks++;
            if (cpu_clk_en !== wantEn) begin errors++; $display("[TB] FAIL run_clk_en cycle %0d: got %b want %b", k, cpu_clk_en, wantEn); end
        end
        btn_run_n = 1'b1;
        run_cycles(12);
        checks++;
        if (state_o !== RUNNING || cpu_clk_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_held: state %0d en %b, want %0d en 1", state_o, cpu_clk_en, RUNNING);
        end
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL run_pending: %0d transitions missing, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    task automatic test_step_running();
        btn_step_n = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            run_cycles(1);
            checks++;
            if (cpu_clk_en !== 1'b1 || state_o !== RUNNING) begin
                errors++;
                $display("[TB] FAIL step_running cycle %0d: state %0d en %b, want %0d en 1", k, state_o, cpu_clk_en, RUNNING);
            end
        end
        btn_step_n = 1'b1;
        run_cycles(10);
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL step_running_pending: %0d left, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    task automatic test_simultaneous();
        int   t0;
        logic wantNS;
        logic wantEn;
        t0 = cyc;
        btn_run_n  = 1'b0;
        btn_halt_n = 1'b0;
        expectState(PULSE_HALT, t0 + 7);
        expectState(HALTED, t0 + 10);
        for (int k = 1; k <= 13; k++) begin
            run_cycles(1);
            wantNS = (k == 7 || k == 8) ? 1'b0 : 1'b1;
            wantEn = (k <= 6);
            checks++;
            if (latch_nS !== wantNS) begin errors++; $display("[TB] FAIL halt_nS cycle %0d: got %b want %b", k, latch_nS, wantNS); end
            checks++;
            if (latch_nR !== 1'b1) begin errors++; $display("[TB] FAIL halt_nR cycle %0d: got %b want 1", k, latch_nR); end
            checks++;
            if (cpu_clk_en !== wantEn) begin errors++; $display("[TB] FAIL halt_clk_en cycle %0d: got %b want %b", k, cpu_clk_en, wantEn); end
        end
        btn_run_n  = 1'b1;
        btn_halt_n = 1'b1;
        run_cycles(10);
        checks++;
        if (state_o !== HALTED || fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_final: state %0d fault %b, want %0d fault 0", state_o, fault, HALTED);
        end
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL halt_pending: %0d left, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    task automatic test_step_halted();
        int   t0;
        logic wantEn;
        t0 = cyc;
        btn_step_n = 1'b0;
        expectState(STEP, t0 + 7);
        expectState(HALTED, t0 + 8);
        for (int k = 1; k <= 12; k++) begin
            run_cycles(1);
            wantEn = (k == 7);
            checks++;
            if (cpu_clk_en !== wantEn) begin errors++; $display("[TB] FAIL step_clk_en cycle %0d: got %b want %b", k, cpu_clk_en, wantEn); end
            checks++;
            if ({latch_nS, latch_nR} !== 2'b11) begin errors++; $display("[TB] FAIL step_pins cycle %0d: got %b%b want 11", k, latch_nS, latch_nR); end
        end
        btn_step_n = 1'b1;
        run_cycles(10);
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL step_pending: %0d left, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    task automatic test_bounce();
        int t0;
        int lowCnt;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            btn_run_n = k[0];
            run_cycles(1);
        end
        btn_run_n = 1'b0;
        expectState(PULSE_RUN, t0 + 11);
        expectState(RUNNING, t0 + 14);
        lowCnt = 0;
        for (int k = 0; k < 16; k++) begin
            run_cycles(1);
            if (latch_nR === 1'b0) lowCnt++;
        end
        checks++;
        if (lowCnt != 2) begin errors++; $display("[TB] FAIL bounce_pulse: nR low %0d cycles, want 2", lowCnt); end
        checks++;
        if (state_o !== RUNNING) begin errors++; $display("[TB] FAIL bounce_state: got %0d want %0d", state_o, RUNNING); end
        btn_run_n = 1'b1;
        run_cycles(10);
        t0 = cyc;
        btn_halt_n = 1'b0;
        expectState(PULSE_HALT, t0 + 7);
        expectState(HALTED, t0 + 10);
        run_cycles(12);
        btn_halt_n = 1'b1;
        run_cycles(10);
        btn_run_n = 1'b0;
        run_cycles(3);
        btn_run_n = 1'b1;
        lowCnt = 0;
        for (int k = 0; k < 15; k++) begin
            run_cycles(1);
            if (latch_nR === 1'b0) lowCnt++;
        end
        checks++;
        if (lowCnt != 0 || state_o !== HALTED) begin
            errors++;
            $display("[TB] FAIL glitch: nR low %0d cycles state %0d, want 0 cycles state %0d", lowCnt, state_o, HALTED);
        end
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL bounce_pending: %0d left, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    task automatic test_stuck_fault();
        int   t0;
        logic wantNS;
        logic wantNR;
        logic wantFault;
        stuckHigh = 1'b1;
        t0 = cyc;
        btn_run_n = 1'b0;
        expectState(PULSE_RUN, t0 + 7);
        expectState(PULSE_HALT, t0 + 10);
        expectState(HALTED, t0 + 13);
        for (int k = 1; k <= 16; k++) begin
            run_cycles(1);
            wantNR    = (k == 7 || k == 8) ? 1'b0 : 1'b1;
            wantNS    = (k == 10 || k == 11) ? 1'b0 : 1'b1;
            wantFault = (k >= 10);
            checks++;
            if (latch_nR !== wantNR) begin errors++; $display("[TB] FAIL stuck_nR cycle %0d: got %b want %b", k, latch_nR, wantNR); end
            checks++;
            if (latch_nS !== wantNS) begin errors++; $display("[TB] FAIL stuck_nS cycle %0d: got %b want %b", k, latch_nS, wantNS); end
            checks++;
            if (fault !== wantFault) begin errors++; $display("[TB] FAIL stuck_fault cycle %0d: got %b want %b", k, fault, wantFault); end
            checks++;
            if (cpu_clk_en !== 1'b0) begin errors++; $display("[TB] FAIL stuck_clk_en cycle %0d: got %b want 0", k, cpu_clk_en); end
        end
        btn_run_n = 1'b1;
        run_cycles(20);
        checks++;
        if (fault !== 1'b1 || state_o !== HALTED) begin
            errors++;
            $display("[TB] FAIL stuck_sticky: fault %b state %0d, want fault 1 state %0d", fault, state_o, HALTED);
        end
        rst_n     = 1'b0;
        stuckHigh = 1'b0;
        run_cycles(1);
        checks++;
        if (fault !== 1'b0) begin errors++; $display("[TB] FAIL stuck_reset_fault: got %b want 0", fault); end
        rst_n = 1'b1;
        run_cycles(2);
        checks++;
        if (fault !== 1'b0 || latch_nS !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stuck_after_reset: fault %b nS %b, want fault 0 nS 1", fault, latch_nS);
        end
        checks++;
        if (sbQueue.size() != 0) begin errors++; $display("[TB] FAIL stuck_pending: %0d left, want 0", sbQueue.size()); sbQueue.delete(); end
    endtask

    initial begin
        test_reset();
        test_run_press();
        test_step_running();
        test_simultaneous();
        test_step_halted();
        test_bounce();
        test_stuck_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
